// File: rtl/sdram_port_client.sv
// sdram_port_client: queues read/write commands and issues them one at a time on an sdram controller port.
// Define SDRAM_CLIENT_TIMEOUT_EN to abort commands that never complete and flag timeout_err.
module sdram_port_client #(
  parameter int PORT_ADDR_WIDTH = 21,
  parameter int DATA_WIDTH      = 32,
  parameter int DQM_WIDTH       = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int REQ_HOLD_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       init_complete,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [PORT_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]      req_data,
  input  logic [DQM_WIDTH-1:0]       req_byte_en,
  output logic                       rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       done,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [PORT_ADDR_WIDTH-1:0] port_addr,
  output logic [DATA_WIDTH-1:0]      port_data,
  output logic [DQM_WIDTH-1:0]       port_byte_en,
  output logic                       port_wr,
  output logic                       port_rd,
  input  logic                       port_available,
  input  logic                       port_ready,
  input  logic [DATA_WIDTH-1:0]      port_q
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(REQ_HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic                       mem_we   [FIFO_DEPTH];
  logic [PORT_ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]      mem_data [FIFO_DEPTH];
  logic [DQM_WIDTH-1:0]       mem_be   [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic [HW-1:0] hold;
  logic [DATA_WIDTH-1:0] q_lat;
  logic pending, rdy_q, cur_we, push, pop, rise, fin;
  assign push     = req_valid && req_ready;
  assign pop      = state == IDLE && count != '0 && init_complete && port_available;
  assign count_nx = count + CW'(push) - CW'(pop);
  assign rise     = port_ready && !rdy_q;
  // a completion edge on the final hold cycle counts the same as one latched earlier
  assign fin      = (state == WAIT && rise) || (state == ISSUE && hold == '0 && (pending || rise));
  assign busy     = state != IDLE || count != '0;
  always_ff @(posedge clk) begin
    if (push) begin
      mem_we[wr_ptr]   <= req_we;
      mem_addr[wr_ptr] <= req_addr;
      mem_data[wr_ptr] <= req_data;
      mem_be[wr_ptr]   <= req_byte_en;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count     <= count_nx;
      req_ready <= count_nx != CW'(FIFO_DEPTH);
    end
  end
`ifdef SDRAM_CLIENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`else
  assign timeout_err = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hold         <= '0;
      pending      <= 1'b0;
      rdy_q        <= 1'b0;
      cur_we       <= 1'b0;
      q_lat        <= '0;
      port_addr    <= '0;
      port_data    <= '0;
      port_byte_en <= '0;
      port_wr      <= 1'b0;
      port_rd      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      done         <= 1'b0;
`ifdef SDRAM_CLIENT_TIMEOUT_EN
      tcnt         <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      rdy_q     <= port_ready;
      done      <= fin;
      rsp_valid <= fin && !cur_we;
      if (fin && !cur_we) rsp_data <= pending ? q_lat : port_q;
      case (state)
        IDLE: if (pop) begin
          state        <= ISSUE;
          hold         <= HW'(REQ_HOLD_CYCLES - 1);
          pending      <= 1'b0;
          cur_we       <= mem_we[rd_ptr];
          port_addr    <= mem_addr[rd_ptr];
          port_data    <= mem_data[rd_ptr];
          port_byte_en <= mem_be[rd_ptr];
          port_wr      <= mem_we[rd_ptr];
          port_rd      <= !mem_we[rd_ptr];
        end
        ISSUE: begin
          if (rise && !pending) begin
            pending <= 1'b1;
            q_lat   <= port_q;
          end
          if (hold == '0) begin
            port_wr      <= 1'b0;
            port_rd      <= 1'b0;
            port_addr    <= '0;
            port_data    <= '0;
            port_byte_en <= '0;
            state        <= fin ? IDLE : WAIT;
          end else hold <= hold - HW'(1);
        end
        WAIT: if (rise) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef SDRAM_CLIENT_TIMEOUT_EN
      tcnt <= state == IDLE ? '0 : tcnt + TW'(1);
      if (state != IDLE && !fin && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state        <= IDLE;
        port_wr      <= 1'b0;
        port_rd      <= 1'b0;
        port_addr    <= '0;
        port_data    <= '0;
        port_byte_en <= '0;
        done         <= 1'b1;
        timeout_err  <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_sdram_port_client.sv
// tb_sdram_port_client: directed bench for sdram_port_client against a small controller model.
// Build with SDRAM_CLIENT_TIMEOUT_EN defined to cover the timeout path.
module tb_sdram_port_client;
  localparam int AW = 21;
  localparam int DW = 32;
  logic clk = 1'b0, reset_n = 1'b0, init_complete = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [3:0] req_byte_en = '0;
  logic req_ready, rsp_valid, done, busy, timeout_err, port_wr, port_rd;
  logic [DW-1:0] rsp_data, port_data, port_q;
  logic [AW-1:0] port_addr;
  logic [3:0] port_byte_en;
  logic port_available, port_ready;
  always #5 clk = ~clk;

  sdram_port_client #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .init_complete(init_complete),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_data(req_data), .req_byte_en(req_byte_en), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .done(done), .busy(busy), .timeout_err(timeout_err), .port_addr(port_addr),
    .port_data(port_data), .port_byte_en(port_byte_en), .port_wr(port_wr), .port_rd(port_rd),
    .port_available(port_available), .port_ready(port_ready), .port_q(port_q)
  );

  // controller model: mode 0 pulses ready m_delay cycles after accept, 1 answers during the hold, 2 never answers
  logic [31:0] mem [0:63];
  logic avail = 1'b1, ready_r = 1'b0, m_busy = 1'b0, m_we = 1'b0;
  logic [31:0] q_r = '0;
  logic [5:0] m_addr = '0;
  int m_cnt = 0, m_delay = 2, m_mode = 0;
  wire early_hit = m_mode == 1 && (port_wr || port_rd) && !m_busy;
  assign port_available = avail;
  assign port_ready = ready_r | early_hit;
  assign port_q = early_hit ? mem[port_addr[5:0]] : q_r;
  always @(posedge clk) begin
    ready_r <= 1'b0;
    if (!reset_n) m_busy <= 1'b0;
    else if (!m_busy && (port_wr || port_rd)) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      m_we   <= port_wr;
      m_addr <= port_addr[5:0];
      if (port_wr)
        for (int i = 0; i < 4; i++)
          if (port_byte_en[i]) mem[port_addr[5:0]][8*i +: 8] <= port_data[8*i +: 8];
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == m_delay && m_mode == 0) begin
        ready_r <= 1'b1;
        q_r     <= m_we ? 32'h0 : mem[m_addr];
      end
      if (m_cnt > m_delay && !port_wr && !port_rd) m_busy <= 1'b0;
    end
  end

  int cyc = 0, done_cnt = 0, cur_len = 0, last_len = 0, iss_cyc = 0, done_cyc = 0;
  logic prev_req = 1'b0;
  logic [AW-1:0] iss_q[$];
  logic [DW-1:0] rsp_q[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (rsp_valid) rsp_q.push_back(rsp_data);
    if (port_wr || port_rd) begin
      if (!prev_req) begin iss_q.push_back(port_addr); iss_cyc = cyc; cur_len = 0; end
      cur_len++;
    end else if (prev_req) last_len = cur_len;
    prev_req = port_wr || port_rd;
  end

  int tests = 0, fails = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    while (!req_ready && n < 300) begin tick; n++; end
    check("push_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_we = we; req_addr = a; req_data = d; req_byte_en = 4'hF;
    tick;
    req_valid = 1'b0;
  endtask
  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 300) begin tick; n++; end
    check(tag, 64'(done_cnt), 64'(target));
  endtask

  logic [31:0] bd [8] = '{32'h1234, 32'h5678, 32'h9ABC, 32'hDEF0, 32'hFEDC, 32'hBA98, 32'h7654, 32'h3210};

  initial begin
    tick;
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_outs", {rsp_valid, done, busy, timeout_err, port_wr, port_rd}, 64'(0));
    check("rst_buses", {port_addr, port_data, port_byte_en}, 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    reset_n = 1'b1;
    tick;
    // write then read back, gated first by init_complete
    push(1'b1, 21'h002020, 32'h00001234);
    repeat (5) tick;
    check("no_issue_before_init", 64'(iss_q.size()), 64'(0));
    init_complete = 1'b1;
    wait_done(1, "wr_done");
    check("wr_hold_len", 64'(last_len), 64'(2));
    repeat (5) tick;
    check("wr_done_once", 64'(done_cnt), 64'(1));
    push(1'b0, 21'h002020, 32'h0);
    wait_done(2, "rd_done");
    check("rd_latency", 64'(done_cyc - iss_cyc), 64'(5));
    check("rd_rsp_count", 64'(rsp_q.size()), 64'(1));
    check("rd_data", 64'(rsp_q[0]), 64'(32'h1234));
    // burst: fill the FIFO while the port is unavailable
    avail = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b1, 21'h002020 + AW'(i), bd[i]);
    check("full_ready_low", 64'(req_ready), 64'(0));
    check("full_no_issue", 64'(iss_q.size()), 64'(2));
    avail = 1'b1;
    for (int i = 4; i < 8; i++) push(1'b1, 21'h002020 + AW'(i), bd[i]);
    wait_done(10, "burst_wr_done");
    check("wr_keeps_rsp", 64'(rsp_data), 64'(32'h1234));
    for (int i = 0; i < 8; i++) check("burst_order", 64'(iss_q[2+i]), 64'(21'h002020 + i));
    for (int i = 0; i < 8; i++) push(1'b0, 21'h002020 + AW'(i), 32'h0);
    wait_done(18, "burst_rd_done");
    check("burst_rsp_count", 64'(rsp_q.size()), 64'(9));
    for (int i = 0; i < 8; i++) check("burst_rd_data", 64'(rsp_q[1+i]), 64'(bd[i]));
    // refresh stall
    avail = 1'b0;
    push(1'b0, 21'h002022, 32'h0);
    repeat (50) tick;
    check("stall_no_rd", 64'(iss_q.size()), 64'(18));
    check("stall_busy", 64'(busy), 64'(1));
    avail = 1'b1;
    wait_done(19, "stall_done");
    check("stall_data", 64'(rsp_q[rsp_q.size()-1]), 64'(32'h9ABC));
    // early completion during the hold window
    m_mode = 1;
    push(1'b0, 21'h002023, 32'h0);
    wait_done(20, "early_done");
    check("early_latency", 64'(done_cyc - iss_cyc), 64'(2));
    check("early_hold_len", 64'(last_len), 64'(2));
    check("early_data", 64'(rsp_q[rsp_q.size()-1]), 64'(32'hDEF0));
    m_mode = 0;
    // reset while a read waits and two more are queued
    m_delay = 20;
    push(1'b0, 21'h002024, 32'h0);
    push(1'b0, 21'h002025, 32'h0);
    push(1'b0, 21'h002026, 32'h0);
    repeat (4) tick;
    check("pre_rst_busy", 64'(busy), 64'(1));
    check("pre_rst_issued", 64'(iss_q.size()), 64'(21));
    reset_n = 1'b0;
    #1;
    check("mid_rst_outs", {rsp_valid, done, busy, port_wr, port_rd}, 64'(0));
    check("mid_rst_buses", {port_addr, port_data, port_byte_en}, 64'(0));
    check("mid_rst_ready", 64'(req_ready), 64'(1));
    repeat (3) tick;
    reset_n = 1'b1;
    m_delay = 2;
    repeat (30) tick;
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_no_issue", 64'(iss_q.size()), 64'(21));
    check("post_rst_no_done", 64'(done_cnt), 64'(20));
    check("post_rst_no_rsp", 64'(rsp_q.size()), 64'(11));
`ifdef SDRAM_CLIENT_TIMEOUT_EN
    m_mode = 2;
    push(1'b0, 21'h002021, 32'h0);
    wait_done(21, "tmo_done");
    check("tmo_latency", 64'(done_cyc - iss_cyc), 64'(16));
    check("tmo_no_rsp", 64'(rsp_q.size()), 64'(11));
    check("tmo_err", 64'(timeout_err), 64'(1));
    m_mode = 0;
    push(1'b0, 21'h002021, 32'h0);
    wait_done(22, "after_tmo_done");
    check("after_tmo_data", 64'(rsp_q[rsp_q.size()-1]), 64'(32'h5678));
    check("tmo_err_sticky", 64'(timeout_err), 64'(1));
`else
    push(1'b0, 21'h002021, 32'h0);
    wait_done(21, "final_rd_done");
    check("final_rd_data", 64'(rsp_q[rsp_q.size()-1]), 64'(32'h5678));
    check("no_tmo_err", 64'(timeout_err), 64'(0));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, observed time %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/sdram_port_client.md
# sdram_port_client

Request-side initiator for one port of the `sdram` controller: drives `port_addr`/`port_data`/`port_byte_en`/`port_wr`/`port_rd` and consumes `port_available`/`port_ready`/`port_q`. User logic pushes read/write commands through a valid/ready interface into a small command FIFO. The block issues them one at a time with the controller's hold-then-wait handshake and returns read data as single-cycle response pulses. It replaces the hand-timed request sequencing currently done in benches and in each client.

## Interface
- `PORT_ADDR_WIDTH`, 21, word address width; matches controller.
- `DATA_WIDTH`, 32, data width.
- `DQM_WIDTH`, 4, byte-enable width.
- `FIFO_DEPTH`, 4, command FIFO entries; power of two, ≥2.
- `REQ_HOLD_CYCLES`, 2, cycles `port_wr`/`port_rd` is held asserted per command; ≥1.
- `TIMEOUT_CYCLES`, 1024, completion timeout; used only with `SDRAM_CLIENT_TIMEOUT_EN`.
- `clk`  in  1  single clock; controller `clk` domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `init_complete`  in  1  controller initialisation done.
- `req_valid`  in  1  command offered.
- `req_ready`  out  1  FIFO not full.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  PORT_ADDR_WIDTH  command address.
- `req_data`  in  DATA_WIDTH  write data.
- `req_byte_en`  in  DQM_WIDTH  byte enables.
- `rsp_valid`  out  1  one-cycle pulse; read data valid.
- `rsp_data`  out  DATA_WIDTH  read data.
- `done`  out  1  one-cycle pulse per retired command, read or write.
- `busy`  out  1  FSM not IDLE or FIFO non-empty.
- `timeout_err`  out  1  sticky timeout flag.
- `port_addr`  out  PORT_ADDR_WIDTH; `port_data`  out  DATA_WIDTH; `port_byte_en`  out  DQM_WIDTH.
- `port_wr`  out  1; `port_rd`  out  1.
- `port_available`  in  1; `port_ready`  in  1; `port_q`  in  DATA_WIDTH.

## Operation
- Push: a command is written into the FIFO when `req_valid && req_ready`. Fields stored: we, addr, data, byte_en.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE → ISSUE:
  - Condition: FIFO non-empty, `init_complete`, and `port_available`.
  - Pop the head and register it onto the `port_*` buses.
  - Assert `port_wr` if we=1, otherwise `port_rd`.
  - Load hold counter with `REQ_HOLD_CYCLES-1`.
- ISSUE: decrement the hold counter. At 0, deassert `port_wr`/`port_rd` and zero `port_addr`, `port_data`, `port_byte_en`.
  - If completion was already latched, go to IDLE and retire the command.
  - Otherwise go to WAIT.
- Completion = rising edge of `port_ready` (registered previous value; 0 after reset).
  - A completion edge seen in ISSUE is latched in a pending flag.
  - A completion edge seen in WAIT retires the command and returns to IDLE.
- Retire:
  - `done` pulses.
  - For reads, `rsp_data` ← `port_q` sampled on the completion-edge cycle, and `rsp_valid` pulses.
  - Writes leave `rsp_data` unchanged.
- Only one command is outstanding; commands retire in FIFO order.
- `port_available` low (refresh, other port) stalls IDLE indefinitely; FIFO keeps accepting until full.

## Timing
- Reset values: `req_ready`=1; all other outputs 0, including the `port_*` buses. FIFO empty, FSM IDLE.
- Asynchronous reset mid-operation aborts the outstanding command immediately: request lines drop and no `done`/`rsp_valid` is issued. The FIFO is flushed.
- Command issue: `port_wr`/`port_rd` rises on the clock edge after IDLE sees the issue condition, and stays high exactly `REQ_HOLD_CYCLES` cycles.
- Response: `rsp_valid`/`done` assert one cycle after the completion-edge cycle. With a pending completion, they assert in the cycle after ISSUE ends.
- Empty FIFO plus push: the command can issue no earlier than 1 cycle after the push cycle. There is no bypass.
- Full FIFO: `req_ready`=0, and a pop in the same cycle does not re-enable it until the next cycle. `req_ready` is registered from the count.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth; the count is one bit wider.
- `port_ready` held high across commands produces no completion; an edge is required.

## Configuration
- `SDRAM_CLIENT_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT_CYCLES+1)`-bit counter clears when entering ISSUE and increments in ISSUE/WAIT.
  - On reaching `TIMEOUT_CYCLES` without completion, the FSM returns to IDLE, `done` pulses, `rsp_valid` stays 0, and `timeout_err` sets and holds until reset.
- Macro not defined: no counter. WAIT waits for completion forever, and `timeout_err` is tied to 0.

## Test plan
- Write, then read back: push write 0x002020/0x00001234/be 0xF, then read 0x002020. Required: `port_wr` high 2 cycles, `done` once; read returns `rsp_valid` with `rsp_data`=0x00001234.
- Burst of eight writes: 0x002020..0x002027 with data 0x1234, 0x5678, 0x9ABC, 0xDEF0, 0xFEDC, 0xBA98, 0x7654, 0x3210 pushed back-to-back. Required: `req_ready` drops after 4 pushes; commands issue in order; reads return the matching data.
- Refresh stall: hold `port_available`=0 for 50 cycles with a read of 0x002022 queued. Required: no `port_rd` until `port_available` rises; then data 0x9ABC is returned.
- Early completion: the controller model pulses `port_ready` during the hold window. Required: the command retires one cycle after ISSUE ends, with no hang in WAIT.
- Reset mid-WAIT: deassert `reset_n` while a read is outstanding with 2 commands queued. Required: all outputs 0 immediately, no `rsp_valid`, and `busy`=0 after release.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): the model never asserts `port_ready`. Required: `done` at cycle 16 after issue, `timeout_err`=1 sticky, next command proceeds normally.
